fwd_hazard_unit: RTL and testbench

Parametrised successor to the two-operand forwarding unit. It tracks in-flight register writes in an internal shift pipeline that mirrors the EX..WB stages. For each instruction leaving ID it computes registered forward selects for NUM_SRC source operands across FWD_DEPTH producer stages, and it detects load-use hazards against a configurable load-data stage. It sits beside the ID/EX register and drives the EX-stage operand muxes and the IF/ID stall.

---
 rtl/fwd_hazard_unit.sv | 98 +++++++++
 tb/tb_fwd_hazard_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - parametrised operand forwarding and load-use hazard unit
module fwd_hazard_unit #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      stall_ext,
  input  logic                      flush,
  output logic                      hazard_stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [CNT_W-1:0]          stall_count
);

  // Entry 0 is the instruction currently in EX; higher indices are older.
  logic [FWD_DEPTH-1:0]             ent_valid_q;
  logic [FWD_DEPTH-1:0]             ent_wr_q;
  logic [FWD_DEPTH-1:0]             ent_ld_q;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] ent_rd_q;

  logic [NUM_SRC*SEL_W-1:0]         fwd_sel_q;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel_d;
  logic [NUM_SRC*SEL_W-1:0]         sel_raw;
  logic [CNT_W-1:0]                 cnt_q;
  logic [FWD_DEPTH-1:0]             producer;
  logic [NUM_SRC-1:0][FWD_DEPTH-1:0] match;
  logic                             haz_raw;
  logic                             bubble;

  always_comb begin
    producer = '0;
    match    = '0;
    sel_raw  = '0;
    haz_raw  = 1'b0;
    for (int j = 0; j < FWD_DEPTH; j++) begin
      producer[j] = ent_valid_q[j] & ent_wr_q[j] & (ent_rd_q[j] != '0);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < FWD_DEPTH; j++) begin
        match[i][j] = id_valid & id_rs_used[i] & producer[j] &
                      (ent_rd_q[j] == id_rs[i*REG_AW +: REG_AW]);
        if (match[i][j] && ent_ld_q[j] && (j + 1 < LOAD_STAGE)) begin
          haz_raw = 1'b1;
        end
      end
      // Scan oldest to youngest so the youngest matching producer wins.
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
        if (match[i][j]) begin
          sel_raw[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
        end
      end
    end
  end

  assign hazard_stall = ~flush & haz_raw;
  assign bubble       = hazard_stall | flush | ~id_valid;
  assign fwd_sel_d    = bubble ? '0 : sel_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid_q <= '0;
      ent_wr_q    <= '0;
      ent_ld_q    <= '0;
      ent_rd_q    <= '0;
      fwd_sel_q   <= '0;
      cnt_q       <= '0;
    end else if (!stall_ext) begin
      for (int j = 1; j < FWD_DEPTH; j++) begin
        ent_valid_q[j] <= ent_valid_q[j-1];
        ent_wr_q[j]    <= ent_wr_q[j-1];
        ent_ld_q[j]    <= ent_ld_q[j-1];
        ent_rd_q[j]    <= ent_rd_q[j-1];
      end
      ent_valid_q[0] <= ~bubble;
      ent_wr_q[0]    <= ~bubble & id_reg_write;
      ent_ld_q[0]    <= ~bubble & id_is_load;
      ent_rd_q[0]    <= bubble ? '0 : id_rd;
      fwd_sel_q      <= fwd_sel_d;
      if (hazard_stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign fwd_sel     = fwd_sel_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - table-driven bench for fwd_hazard_unit (default and deep configs)
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [1:0]  id_rs_used = '0;
  logic [4:0]  id_rd = '0;
  logic        id_reg_write = 1'b0;
  logic        id_is_load = 1'b0;
  logic        stall_ext = 1'b0;
  logic        flush = 1'b0;

  logic        haz_a;
  logic [3:0]  fwd_a;
  logic [15:0] cnt_a;
  logic        haz_b;
  logic [2:0]  fwd_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .stall_ext(stall_ext), .flush(flush),
    .hazard_stall(haz_a), .fwd_sel(fwd_a), .stall_count(cnt_a)
  );

  fwd_hazard_unit #(.NUM_SRC(1), .FWD_DEPTH(4), .LOAD_STAGE(3), .REG_AW(5), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs[4:0]),
    .id_rs_used(id_rs_used[0]), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .stall_ext(stall_ext), .flush(flush),
    .hazard_stall(haz_b), .fwd_sel(fwd_b), .stall_count(cnt_b)
  );

  typedef struct {
    bit          b;
    bit          rst;
    bit          v;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [1:0]  used;
    logic [4:0]  rd;
    bit          wr;
    bit          ld;
    bit          sx;
    bit          fl;
    bit          eh;
    logic [2:0]  ef0;
    logic [2:0]  ef1;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(bit b, bit rst, bit v, int rs0, int rs1, int used, int rd,
                              bit wr, bit ld, bit sx, bit fl, bit eh, int ef0, int ef1, int ec);
    vec_t r;
    r.b = b; r.rst = rst; r.v = v;
    r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used); r.rd = 5'(rd);
    r.wr = wr; r.ld = ld; r.sx = sx; r.fl = fl; r.eh = eh;
    r.ef0 = 3'(ef0); r.ef1 = 3'(ef1); r.ec = 16'(ec);
    return r;
  endfunction

  task automatic chk(input int row, input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0d expected %0d", row, nm, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Default configuration: e0 = EX, e1 = MEM; loads forward only from stage 2.
    vecs.push_back(mk(0,0,0, 0, 0,0, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 0, 0,0, 5,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 5, 5,3, 6,1,0,0,0, 0,1,1,0));
    vecs.push_back(mk(0,1,1, 0, 0,0, 5,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 1, 2,3,10,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 5, 5,3, 6,1,0,0,0, 0,2,2,0));
    vecs.push_back(mk(0,1,1, 0, 0,0, 5,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 0, 0,0,11,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 0, 0,0,12,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 5, 5,3,13,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 0, 0,0, 7,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 0, 0,0, 7,1,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 7, 1,3, 8,1,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,1,1, 0, 0,0, 3,1,1,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 3, 0,3, 4,1,0,0,0, 1,0,0,1));
    vecs.push_back(mk(0,1,1, 3, 0,3, 4,1,0,0,0, 0,2,0,1));
    vecs.push_back(mk(0,1,1, 0, 0,0, 3,1,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1,1, 3, 2,2,14,1,0,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1,1, 0, 0,0, 0,1,0,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1,1, 0, 0,3,15,1,0,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1,1, 0, 0,0, 3,1,1,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1,1, 3, 0,1,16,1,0,0,1, 0,0,0,1));
    vecs.push_back(mk(0,1,1,16, 3,3,17,1,0,0,0, 0,0,2,1));
    vecs.push_back(mk(0,1,1, 0, 0,0,21,1,0,0,0, 0,0,0,1));
    vecs.push_back(mk(0,1,1,21,17,3,22,1,1,0,0, 0,1,2,1));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,1,1,22,21,3,23,1,0,1,0, 1,1,2,1));
    vecs.push_back(mk(0,1,1,22,21,3,23,1,0,0,0, 1,0,0,2));
    vecs.push_back(mk(0,1,1,22,21,3,23,1,0,0,0, 0,2,0,2));
    vecs.push_back(mk(0,1,1, 0, 0,0, 5,1,1,0,0, 0,0,0,2));
    vecs.push_back(mk(0,0,1, 5, 0,1, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1, 5, 0,1, 0,0,0,0,0, 0,0,0,0));
    // Deep configuration: 4 producer stages, load data from stage 3, 2-bit counter.
    vecs.push_back(mk(1,0,0, 0, 0,0, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,1, 0, 0,0, 7,1,0,0,0, 0,0,0,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1,1,1,0,0,0,0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,1, 7, 0,1, 0,0,0,0,0, 0,4,0,0));
    vecs.push_back(mk(1,1,1, 0, 0,0, 3,1,1,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,1, 0, 0,0, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 1,0,0,1));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 0,3,0,1));
    vecs.push_back(mk(1,1,1, 0, 0,0, 3,1,1,0,0, 0,0,0,1));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 1,0,0,2));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 1,0,0,3));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 0,3,0,3));
    vecs.push_back(mk(1,1,1, 0, 0,0, 3,1,1,0,0, 0,0,0,3));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 1,0,0,3));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 1,0,0,3));
    vecs.push_back(mk(1,1,1, 3, 0,1, 0,0,0,0,0, 0,3,0,3));

    @(negedge clk);
    foreach (vecs[k]) begin
      rst_n        = vecs[k].rst;
      id_valid     = vecs[k].v;
      id_rs        = {vecs[k].rs1, vecs[k].rs0};
      id_rs_used   = vecs[k].used;
      id_rd        = vecs[k].rd;
      id_reg_write = vecs[k].wr;
      id_is_load   = vecs[k].ld;
      stall_ext    = vecs[k].sx;
      flush        = vecs[k].fl;
      #2;
      if (vecs[k].b) begin
        chk(k, "hazard_stall_b", 16'(haz_b), 16'(vecs[k].eh));
        if (!vecs[k].rst) chk(k, "async_rst_cnt_b", 16'(cnt_b), 16'd0);
      end else begin
        chk(k, "hazard_stall_a", 16'(haz_a), 16'(vecs[k].eh));
        if (!vecs[k].rst) begin
          chk(k, "async_rst_fwd_a", 16'(fwd_a), 16'd0);
          chk(k, "async_rst_cnt_a", cnt_a, 16'd0);
        end
      end
      @(posedge clk);
      #1;
      if (vecs[k].b) begin
        chk(k, "fwd_sel_b", 16'(fwd_b), 16'(vecs[k].ef0));
        chk(k, "stall_count_b", 16'(cnt_b), 16'(vecs[k].ec[1:0]));
      end else begin
        chk(k, "fwd_sel0_a", 16'(fwd_a[1:0]), 16'(vecs[k].ef0[1:0]));
        chk(k, "fwd_sel1_a", 16'(fwd_a[3:2]), 16'(vecs[k].ef1[1:0]));
        chk(k, "stall_count_a", cnt_a, vecs[k].ec);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
